// File: rtl/vu_pkg.sv
// Shared types and constants for the VU frame sequencer and its gap timer.
package vu_pkg;
    localparam int PIX_W = 24;
    localparam logic [PIX_W-1:0] PIX_OFF = 24'h000000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ZERO,
        SEND,
        GAP
    } state_t;
endpackage

// File: rtl/gap_timer.sv
// Load/count/done timer: after i_load it runs GAP_CYCLES cycles, then pulses o_done on the last one.
module gap_timer #(
    parameter int GAP_CYCLES = 600
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          w_last;

    assign w_last = (r_cnt == CW'(GAP_CYCLES - 1));
    assign o_done = r_run && w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (w_last) r_run <= 1'b0;
            else        r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vu_frame_sequencer.sv
// Turns one VU level strobe into a NUM_LEDS pixel frame: lit pixels read from the colour ROM,
// unlit pixels forced black, then a latch gap before the next frame may start.
module vu_frame_sequencer
    import vu_pkg::*;
#(
    parameter int NUM_LEDS   = 20,
    parameter int ADDR       = 256,
    parameter int ROM_BASE   = 0,
    parameter int GAP_CYCLES = 600,
    localparam int AW = $clog2(ADDR),
    localparam int LW = $clog2(NUM_LEDS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [LW-1:0]    i_level,
    input  logic             i_level_valid,
    output logic [AW-1:0]    o_rom_addr,
    output logic             o_rom_ren,
    input  logic [PIX_W-1:0] i_rom_data,
    output logic [PIX_W-1:0] o_pix_data,
    output logic             o_pix_valid,
    input  logic             i_pix_ready,
    output logic             o_busy,
    output logic             o_frame_done
);
    state_t            r_state, w_nxt;
    logic [LW-1:0]     r_lvl, r_pend_lvl, r_idx;
    logic              r_pend;
    logic [PIX_W-1:0]  r_pix;
    logic [AW-1:0]     r_addr;

    logic [LW-1:0]     w_sat, w_start_lvl, w_idx_nxt;
    logic              w_start, w_hs, w_last, w_more, w_gap_done;

    assign w_sat       = (i_level > LW'(NUM_LEDS)) ? LW'(NUM_LEDS) : i_level;
    // A strobe in the consuming cycle overrides the stored pending level.
    assign w_start     = (r_state == IDLE) && (i_level_valid || r_pend);
    assign w_start_lvl = i_level_valid ? w_sat : r_pend_lvl;
    assign w_hs        = (r_state == SEND) && i_pix_ready;
    assign w_last      = (r_idx == LW'(NUM_LEDS - 1));
    assign w_more      = ((LW+1)'(r_idx) + (LW+1)'(1)) < (LW+1)'(r_lvl);
    assign w_idx_nxt   = (r_state == IDLE) ? '0 : r_idx + 1'b1;

    assign o_rom_addr  = r_addr;
    assign o_pix_data  = r_pix;

    gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_hs && w_last),
        .o_done  (w_gap_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_nxt = (w_start_lvl != '0) ? FETCH : ZERO;
            FETCH:   w_nxt = CAPTURE;
            CAPTURE: w_nxt = SEND;
            ZERO:    w_nxt = SEND;
            SEND:    if (i_pix_ready) w_nxt = w_last ? GAP : (w_more ? FETCH : ZERO);
            GAP:     if (w_gap_done) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_rom_ren    = 1'b0;
        o_pix_valid  = 1'b0;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        if (r_state != IDLE) o_busy = 1'b1;
        if (r_state == FETCH) o_rom_ren = 1'b1;
        if (r_state == SEND) begin
            o_pix_valid  = 1'b1;
            o_frame_done = i_pix_ready && w_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lvl      <= '0;
            r_pend_lvl <= '0;
            r_pend     <= 1'b0;
            r_idx      <= '0;
            r_pix      <= '0;
            r_addr     <= '0;
        end else begin
            if (w_start) begin
                r_lvl  <= w_start_lvl;
                r_idx  <= '0;
                r_pend <= 1'b0;
            end else if (i_level_valid) begin
                r_pend     <= 1'b1;
                r_pend_lvl <= w_sat;
            end
            if (w_hs && !w_last) r_idx <= r_idx + 1'b1;
            // Address is set on FETCH entry and held until the next FETCH.
            if (w_nxt == FETCH) r_addr <= AW'(ROM_BASE) + AW'(w_idx_nxt);
            // ROM data is only meaningful in CAPTURE; it floats everywhere else.
            if (r_state == CAPTURE) r_pix <= i_rom_data;
            else if (r_state == ZERO) r_pix <= PIX_OFF;
        end
    end
endmodule
